// File: rtl/copro_arb.sv
// Round-robin arbiter that shares one 32x32->64 multiply coprocessor among NREQ clients.
// Each grant sequences push A, push B, start, wait ready, pop hi, pop lo, then responds.
module copro_arb #(
    parameter int NREQ = 2,
    parameter int TMO  = 255
) (
    input  logic                 i_ck,
    input  logic                 i_rb,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*32-1:0]   i_opa,
    input  logic [NREQ*32-1:0]   i_opb,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_rsp_vld,
    output logic [63:0]          o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_cp_start,
    input  logic                 i_cp_ready,
    output logic                 o_cp_dpsh,
    output logic [31:0]          o_cp_dinp,
    output logic                 o_cp_dpop,
    input  logic [31:0]          i_cp_dout
);

    // state    | meaning
    // IDLE     | no transaction, arbitrating
    // PUSH_A   | pushing operand A
    // PUSH_B   | pushing operand B
    // GAP      | idle cycle between pushes and start
    // START    | start pulse to coprocessor
    // WAIT     | waiting for cp_ready rising edge or timeout
    // POP_HI   | popping result[63:32]
    // POP_LO   | popping result[31:0]
    // RESP     | response pulse to the granted requester
    typedef enum logic [3:0] {
        S_IDLE, S_PUSH_A, S_PUSH_B, S_GAP, S_START,
        S_WAIT, S_POP_HI, S_POP_LO, S_RESP
    } state_t;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    state_t             r_state;
    logic [IW-1:0]      r_rr;
    logic [IW-1:0]      r_idx;
    logic [31:0]        r_opb;
    logic [31:0]        r_hi;
    logic [CW-1:0]      r_cnt;
    logic               r_rdy_prev;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_rsp_vld;
    logic [63:0]        r_rsp_data;
    logic               r_rsp_err;
    logic               r_cp_start;
    logic               r_cp_dpsh;
    logic [31:0]        r_cp_dinp;
    logic               r_cp_dpop;

    logic               w_pick_vld;
    logic [IW-1:0]      w_pick_idx;
    logic [NREQ-1:0]    w_pick_oh;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [IW-1:0]      w_rr_next;
    logic               w_rdy_edge;

    // Scan from the farthest candidate down so the one nearest the pointer wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(r_rr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (i_req[j]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = IW'(j);
            end
        end
    end

    assign w_pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_sel_a    = i_opa[32*w_pick_idx +: 32];
    assign w_sel_b    = i_opb[32*w_pick_idx +: 32];
    assign w_rr_next  = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_rdy_edge = i_cp_ready && !r_rdy_prev;

    always_ff @(posedge i_ck or posedge i_rb) begin
        if (i_rb) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_idx      <= '0;
            r_opb      <= '0;
            r_hi       <= '0;
            r_cnt      <= '0;
            r_rdy_prev <= 1'b0;
            r_gnt      <= '0;
            r_rsp_vld  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_cp_start <= 1'b0;
            r_cp_dpsh  <= 1'b0;
            r_cp_dinp  <= '0;
            r_cp_dpop  <= 1'b0;
        end else begin
            r_rdy_prev <= i_cp_ready;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_idx     <= w_pick_idx;
                        r_opb     <= w_sel_b;
                        r_gnt     <= w_pick_oh;
                        r_cp_dpsh <= 1'b1;
                        r_cp_dinp <= w_sel_a;
                        r_state   <= S_PUSH_A;
                    end
                end
                S_PUSH_A: begin
                    r_cp_dinp <= r_opb;
                    r_state   <= S_PUSH_B;
                end
                S_PUSH_B: begin
                    r_cp_dpsh <= 1'b0;
                    r_cp_dinp <= '0;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    r_cp_start <= 1'b1;
                    r_cnt      <= CW'(TMO - 1);
                    r_state    <= S_START;
                end
                S_START: begin
                    r_cp_start <= 1'b0;
                    r_state    <= S_WAIT;
                end
                // A ready edge on the final counted cycle still wins over the timeout.
                S_WAIT: begin
                    if (w_rdy_edge) begin
                        r_cp_dpop <= 1'b1;
                        r_state   <= S_POP_HI;
                    end else if (r_cnt == '0) begin
                        r_rsp_vld  <= r_gnt;
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_POP_HI: begin
                    r_hi    <= i_cp_dout;
                    r_state <= S_POP_LO;
                end
                S_POP_LO: begin
                    r_cp_dpop  <= 1'b0;
                    r_rsp_vld  <= r_gnt;
                    r_rsp_data <= {r_hi, i_cp_dout};
                    r_rsp_err  <= 1'b0;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_vld  <= '0;
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b0;
                    r_gnt      <= '0;
                    r_rr       <= w_rr_next;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rsp_vld  = r_rsp_vld;
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_err  = r_rsp_err;
    assign o_cp_start = r_cp_start;
    assign o_cp_dpsh  = r_cp_dpsh;
    assign o_cp_dinp  = r_cp_dinp;
    assign o_cp_dpop  = r_cp_dpop;

endmodule

// File: tb/tb_copro_arb.sv
// Self-checking bench for copro_arb: behavioural coprocessor plus a transaction-level
// round-robin/product model, directed scenarios followed by randomized traffic.
module tb_copro_arb;

    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*32-1:0]  opa;
    logic [NREQ*32-1:0]  opb;
    logic [NREQ-1:0]     o_gnt;
    logic [NREQ-1:0]     o_rsp_vld;
    logic [63:0]         o_rsp_data;
    logic                o_rsp_err;
    logic                o_cp_start;
    logic                cp_ready;
    logic                o_cp_dpsh;
    logic [31:0]         o_cp_dinp;
    logic                o_cp_dpop;
    logic [31:0]         cp_dout;

    copro_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
        .i_ck       (clk),
        .i_rb       (rst),
        .i_req      (req),
        .i_opa      (opa),
        .i_opb      (opb),
        .o_gnt      (o_gnt),
        .o_rsp_vld  (o_rsp_vld),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err),
        .o_cp_start (o_cp_start),
        .i_cp_ready (cp_ready),
        .o_cp_dpsh  (o_cp_dpsh),
        .o_cp_dinp  (o_cp_dinp),
        .o_cp_dpop  (o_cp_dpop),
        .i_cp_dout  (cp_dout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // coprocessor model state and reference arbitration pointer
    logic [31:0] push_q[$];
    int          n_start;
    int          n_pop;
    int          pop_idx;
    int          rdy_cnt;
    int          cfg_delay;
    bit          cfg_hang;
    logic [63:0] cp_prod;
    int          rr_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic cp_step();
        int busy;
        busy = int'(o_cp_dpsh) + int'(o_cp_dpop) + int'(o_cp_start);
        chk("excl", 64'(busy <= 1), 64'(1));
        if (o_cp_dpsh) push_q.push_back(o_cp_dinp);
        else chk("dinp_idle", 64'(o_cp_dinp), 64'(0));
        if (o_cp_start) begin
            n_start++;
            rdy_cnt = cfg_hang ? 0 : cfg_delay;
            cp_prod = (push_q.size() >= 2) ? 64'(push_q[0]) * 64'(push_q[1]) : 64'(0);
            pop_idx = 0;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) cp_ready = 1'b1;
        end
        if (o_cp_dpop) begin
            n_pop++;
            cp_ready = 1'b0;
            cp_dout  = (pop_idx == 0) ? cp_prod[63:32] : cp_prod[31:0];
            pop_idx++;
        end else begin
            cp_dout = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cp_step();
    endtask

    // mode: 0 = served requester drops req, 1 = all req held, 2 = all req dropped
    task automatic run_op(input int d, input bit hang, input int mode, input bit disturb);
        int              ei;
        logic [31:0]     ea;
        logic [31:0]     eb;
        logic [63:0]     exp_data;
        logic [NREQ-1:0] oh;
        int              lat;
        bit              got;
        ei = pick(req, rr_m);
        if (ei < 0) begin
            chk("req_none", 64'(req), 64'(1));
            return;
        end
        ea = opa[32*ei +: 32];
        eb = opb[32*ei +: 32];
        oh = '0;
        oh[ei] = 1'b1;
        cfg_delay = d;
        cfg_hang  = hang;
        push_q.delete();
        n_start = 0;
        n_pop   = 0;
        got = 0;
        for (int t = 0; t < 6 && !got; t++) begin
            tick();
            if (o_gnt != '0) got = 1;
        end
        chk("gnt", 64'(o_gnt), 64'(oh));
        if (!got) return;
        if (disturb) begin
            opa = {$urandom, $urandom};
            opb = {$urandom, $urandom};
            req[ei] = 1'b0;
        end
        lat = 0;
        got = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            tick();
            lat++;
            if (o_rsp_vld != '0) got = 1;
        end
        chk("rsp_vld", 64'(o_rsp_vld), 64'(oh));
        if (!got) return;
        exp_data = hang ? 64'(0) : 64'(ea) * 64'(eb);
        chk("gnt_hold", 64'(o_gnt), 64'(oh));
        chk("rsp_err", 64'(o_rsp_err), 64'(hang));
        chk("rsp_data", o_rsp_data, exp_data);
        chk("latency", 64'(lat), hang ? 64'(4 + TMO) : 64'(6 + d));
        chk("n_push", 64'(push_q.size()), 64'(2));
        if (push_q.size() >= 2) begin
            chk("push_a", 64'(push_q[0]), 64'(ea));
            chk("push_b", 64'(push_q[1]), 64'(eb));
        end
        chk("n_start", 64'(n_start), 64'(1));
        chk("n_pop", 64'(n_pop), hang ? 64'(0) : 64'(2));
        rr_m = (ei + 1) % NREQ;
        if (mode == 0) req[ei] = 1'b0;
        else if (mode == 2) req = '0;
        tick();
        chk("rsp_pulse", 64'(o_rsp_vld), 64'(0));
        chk("gnt_clear", 64'(o_gnt), 64'(0));
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        opa[32*i +: 32] = a;
        opb[32*i +: 32] = b;
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        req = '0;
        opa = '0;
        opb = '0;
        cp_ready = 1'b0;
        cp_dout  = '0;
        rdy_cnt = 0;
        cfg_delay = 1;
        cfg_hang = 0;
        cp_prod = '0;
        pop_idx = 0;
        n_start = 0;
        n_pop = 0;
        rr_m = 0;
        tick();
        tick();
        chk("rst_ctl", 64'({o_gnt, o_rsp_vld, o_rsp_err, o_cp_start, o_cp_dpsh, o_cp_dpop}), 64'(0));
        chk("rst_data", o_rsp_data, 64'(0));
        chk("rst_dinp", 64'(o_cp_dinp), 64'(0));
        rst = 1'b0;
        tick();

        // contention: requester 0 first, then 1
        set_op(0, 32'd3, 32'd5);
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req = 2'b11;
        run_op(2, 0, 0, 0);
        run_op(4, 0, 0, 0);

        // fairness with all requests held
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            set_op(0, $urandom, $urandom);
            set_op(1, $urandom, $urandom);
            run_op($urandom_range(1, 5), 0, (i == 5) ? 2 : 1, 0);
        end

        // single operation with known product
        set_op(0, 32'h1234_5678, 32'hFEDC_BA98);
        req = 2'b01;
        run_op(3, 0, 0, 0);
        chk("known_prod_rr", 64'(rr_m), 64'(1));

        // ready edge in the very first WAIT cycle, and on the last counted one
        req = 2'b10;
        set_op(1, $urandom, $urandom);
        run_op(1, 0, 0, 0);
        req = 2'b01;
        set_op(0, $urandom, $urandom);
        run_op(TMO, 0, 0, 0);

        // timeout, then normal service
        req = 2'b01;
        set_op(0, $urandom, $urandom);
        run_op(1, 1, 0, 0);
        req = 2'b01;
        set_op(0, 32'hDEAD_BEEF, 32'h0000_0010);
        run_op(5, 0, 0, 0);

        // reset during WAIT
        req = 2'b01;
        set_op(0, $urandom, $urandom);
        cfg_hang = 1;
        push_q.delete();
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (o_cp_start) got = 1;
        end
        chk("start_seen", 64'(got), 64'(1));
        tick();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({o_gnt, o_rsp_vld, o_rsp_err, o_cp_start, o_cp_dpsh, o_cp_dpop}), 64'(0));
        chk("rst_mid_dinp", 64'(o_cp_dinp), 64'(0));
        req = '0;
        cp_ready = 1'b0;
        rdy_cnt = 0;
        cfg_hang = 0;
        rr_m = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", 64'(o_gnt), 64'(0));
        req = 2'b11;
        set_op(0, $urandom, $urandom);
        set_op(1, $urandom, $urandom);
        run_op(2, 0, 2, 0);

        // operands and req disturbed after grant
        req = 2'b10;
        set_op(1, 32'h0001_0001, 32'h0000_FFFF);
        run_op(3, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            req = '0;
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("idle_gnt", 64'(o_gnt), 64'(0));
            end
            opa = {$urandom, $urandom};
            opb = {$urandom, $urandom};
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_op($urandom_range(1, 8), ($urandom_range(0, 9) == 0), 0, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
